mavg_filter: RTL and testbench
==============================

MAVG_FILTER -- requirements
Module: mavg_filter

Interface
REQ-001 Parameter WIDTH, default 8, sample and result width in bits (WIDTH >= 1).
REQ-002 Parameter LOG2_DEPTH, default 2, window depth DEPTH = 2**LOG2_DEPTH (LOG2_DEPTH >= 1).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port clear  input  1  synchronous flush of window, sum and counters.
REQ-006 Port mode  input  mode_e (1 bit)  MODE_SLIDING = 0 (moving average), MODE_BLOCK = 1 (block average, decimate by DEPTH).
REQ-007 Port in_valid  input  1  qualifies in_data for one cycle; no backpressure, every valid sample is accepted.
REQ-008 Port in_data  input  WIDTH  unsigned sample.
REQ-009 Port out_valid  output  1  one-cycle pulse qualifying out_data.
REQ-010 Port out_data  output  WIDTH  unsigned average, held between pulses.
REQ-011 Port warm  output  1  high while the window holds DEPTH samples since the last flush.

Function
REQ-012 Running sum SHALL be WIDTH+LOG2_DEPTH bits unsigned; it never overflows.
REQ-013 Average SHALL be sum >> LOG2_DEPTH (truncation, no rounding).
REQ-014 Sliding: each accepted sample SHALL set sum_next = sum + in_data - oldest, where oldest is the sample leaving the DEPTH-entry ring, taken as 0 while fill count < DEPTH.
REQ-015 Sliding: the ring write pointer SHALL advance by one per accepted sample and wrap from DEPTH-1 to 0.
REQ-016 Sliding: out_valid SHALL pulse the cycle after every accepted sample for which the window is full after that sample (the DEPTH-th sample onward); out_data SHALL be the new average.
REQ-017 Block: each accepted sample SHALL be added to sum; on the DEPTH-th sample, the cycle after, out_valid SHALL pulse with the average of those DEPTH samples, and sum and count SHALL restart at 0.
REQ-018 Block: the ring SHALL be unused.
REQ-019 Latency SHALL be exactly 1 cycle from accepted sample to out_valid; gaps in in_valid SHALL not alter state.
REQ-020 Fill count SHALL saturate at DEPTH in sliding mode; warm SHALL be registered and rise with the first out_valid after a flush.
REQ-021 In block mode, warm SHALL be high for the out_valid cycle only.
REQ-022 clear high SHALL flush sum, fill count, pointer and warm next cycle; a coincident in_valid sample SHALL be dropped; out_data holds; out_valid SHALL be 0 that cycle.
REQ-023 A change of mode between consecutive cycles SHALL act as clear in the cycle it is seen; a coincident sample is dropped.
REQ-024 Ring contents need not be reset; correctness SHALL rely on the fill count masking stale entries.

Reset
REQ-025 rst_n low SHALL asynchronously force sum = 0, fill count = 0, pointer = 0, out_valid = 0, out_data = 0, warm = 0, stored mode = MODE_SLIDING.
REQ-026 Reset SHALL abort any partial window; the first sample after deassertion starts a fresh window.

Structure
REQ-027 Package mavg_pkg SHALL hold typedef enum mode_e {MODE_SLIDING, MODE_BLOCK} and a function computing the sum width.
REQ-028 Sub-module mavg_ring SHALL implement the DEPTH x WIDTH circular buffer (write with pointer, read oldest combinationally); the top holds sum, counters and output registers.
REQ-029 Implementation SHALL be within 120-400 lines of RTL and free of latches.

Verification (WIDTH = 8, LOG2_DEPTH = 2)
REQ-030 Sliding, samples 4, 8, 12, 16 -> no out_valid for the first three; pulse after 16 with out_data = 10 and warm = 1; then sample 20 -> out_data = 14.
REQ-031 Block, samples 1, 2, 3, 4, 5, 6, 7, 8 -> exactly two pulses: out_data = 2, then 6.
REQ-032 Sliding, 255 x 6 -> every pulse out_data = 255, sum never wraps.
REQ-033 Sliding, samples 50, 50, then clear with a coincident sample 200, then 100 x 4 -> first pulse only after the 4th 100, out_data = 100.
REQ-034 Sliding, 3 samples of 40, then rst_n low mid-stream -> all outputs 0 immediately; after release, 80 x 4 -> out_data = 80 on the 4th sample only.
REQ-035 Sliding with warm = 1, mode switched to block, then 8, 8, 8, 8 -> no pulse until the 4th sample, out_data = 8.

Source files
------------

// File: rtl/mavg_pkg.sv
// Shared types and helpers for the moving/block average filter.
// Defines the mode encoding and the sizing function for the running-sum width.
package mavg_pkg;

    typedef enum logic {
        MODE_SLIDING = 1'b0,
        MODE_BLOCK   = 1'b1
    } mode_e;

    // A sum of 2**log2_depth samples of w bits needs log2_depth extra bits.
    function automatic int sum_width(input int w, input int log2_depth);
        return w + log2_depth;
    endfunction

endpackage

// File: rtl/mavg_ring.sv
// DEPTH x WIDTH circular sample buffer.
// The write and read slot share one pointer; the slot about to be overwritten holds the oldest sample.
module mavg_ring #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [LOG2_DEPTH-1:0] ptr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Entries are never reset; the top masks them with its fill count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (ptr == LOG2_DEPTH'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem[ptr];

endmodule

// File: rtl/mavg_filter.sv
// Moving-average / block-average filter over a window of 2**LOG2_DEPTH unsigned samples.
// Results appear one cycle after the sample that completes a window; clear or a mode change flushes all state.
module mavg_filter
    import mavg_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  mode_e            mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             warm
);

    localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    logic [SUM_W-1:0]      sum_reg, sum_next;
    logic [CNT_W-1:0]      fill_reg, fill_next;
    logic [LOG2_DEPTH-1:0] ptr_reg, ptr_next;
    mode_e                 mode_reg;
    logic                  out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]      out_data_reg, out_data_next;
    logic                  warm_reg, warm_next;

    logic                  flush;
    logic                  accept;
    logic                  full;
    logic                  ring_wr;
    logic [WIDTH-1:0]      oldest;
    logic [SUM_W-1:0]      in_ext, old_ext, sum_slide, sum_block;

    mavg_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (clk),
        .wr_en   (ring_wr),
        .ptr     (ptr_reg),
        .wr_data (in_data),
        .rd_data (oldest)
    );

    assign flush  = clear || (mode != mode_reg);
    assign accept = in_valid && !flush;
    assign full   = (fill_reg == FULL_CNT);

    // Until the window is full the departing ring slot is stale, so it counts as zero.
    assign in_ext    = {{LOG2_DEPTH{1'b0}}, in_data};
    assign old_ext   = full ? {{LOG2_DEPTH{1'b0}}, oldest} : '0;
    assign sum_slide = sum_reg + in_ext - old_ext;
    assign sum_block = sum_reg + in_ext;

    always_comb begin
        sum_next       = sum_reg;
        fill_next      = fill_reg;
        ptr_next       = ptr_reg;
        out_valid_next = 1'b0;
        out_data_next  = out_data_reg;
        warm_next      = (mode == MODE_SLIDING) ? warm_reg : 1'b0;
        ring_wr        = 1'b0;

        if (flush) begin
            sum_next  = '0;
            fill_next = '0;
            ptr_next  = '0;
            warm_next = 1'b0;
        end else if (accept) begin
            if (mode == MODE_SLIDING) begin
                ring_wr  = 1'b1;
                sum_next = sum_slide;
                ptr_next = ptr_reg + 1'b1;
                if (!full) begin
                    fill_next = fill_reg + 1'b1;
                end
                if (full || (fill_reg == LAST_CNT)) begin
                    out_valid_next = 1'b1;
                    out_data_next  = sum_slide[SUM_W-1:LOG2_DEPTH];
                    warm_next      = 1'b1;
                end
            end else begin
                if (fill_reg == LAST_CNT) begin
                    out_valid_next = 1'b1;
                    out_data_next  = sum_block[SUM_W-1:LOG2_DEPTH];
                    warm_next      = 1'b1;
                    sum_next       = '0;
                    fill_next      = '0;
                end else begin
                    sum_next  = sum_block;
                    fill_next = fill_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            fill_reg      <= '0;
            ptr_reg       <= '0;
            mode_reg      <= MODE_SLIDING;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            warm_reg      <= 1'b0;
        end else begin
            sum_reg       <= sum_next;
            fill_reg      <= fill_next;
            ptr_reg       <= ptr_next;
            mode_reg      <= mode;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            warm_reg      <= warm_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign warm      = warm_reg;

endmodule

// File: tb/tb_mavg_filter.sv
// Self-checking bench for mavg_filter: directed scenarios plus randomized traffic
// compared against a queue-based window model.
module tb_mavg_filter;
    import mavg_pkg::*;

    localparam int W = 8;
    localparam int L = 2;
    localparam int D = 1 << L;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    mode_e        mode = MODE_SLIDING;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         warm;

    mavg_filter #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .warm      (warm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    // Reference model: the list of samples in the current window.
    int    win_q[$];
    mode_e m_prev = MODE_SLIDING;
    bit    e_valid = 1'b0;
    bit    e_warm = 1'b0;
    int    e_data = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (win_q[i]) s += win_q[i];
        return s;
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_prev  = MODE_SLIDING;
        e_valid = 1'b0;
        e_warm  = 1'b0;
        e_data  = 0;
    endtask

    task automatic model_step(input bit c, input mode_e md, input bit v, input int d);
        bit fl;
        fl = c || (md != m_prev);
        m_prev = md;
        e_valid = 1'b0;
        if (fl) begin
            win_q.delete();
            e_warm = 1'b0;
        end else if (md == MODE_SLIDING) begin
            if (v) begin
                win_q.push_back(d);
                if (win_q.size() > D) void'(win_q.pop_front());
                if (win_q.size() == D) begin
                    e_valid = 1'b1;
                    e_data  = win_sum() / D;
                end
            end
            e_warm = (win_q.size() == D);
        end else begin
            if (v) begin
                win_q.push_back(d);
                if (win_q.size() == D) begin
                    e_valid = 1'b1;
                    e_data  = win_sum() / D;
                    win_q.delete();
                end
            end
            e_warm = e_valid;
        end
    endtask

    task automatic cycle(input bit c, input mode_e md, input bit v, input int d, input string tag);
        logic [31:0] dv;
        dv = d;
        @(negedge clk);
        clear    = c;
        mode     = md;
        in_valid = v;
        in_data  = dv[W-1:0];
        model_step(c, md, v, d);
        @(posedge clk);
        #1;
        check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
        check_val({tag, "_warm"}, {31'd0, warm}, {31'd0, e_warm});
        check_val({tag, "_data"}, {24'd0, out_data}, e_data);
        if (out_valid) begin
            pulses++;
            $display("OUT %s data=%0d warm=%0b", tag, out_data, warm);
        end
    endtask

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val({tag, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_rst_data"}, {24'd0, out_data}, 32'd0);
        check_val({tag, "_rst_warm"}, {31'd0, warm}, 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        mode     = MODE_SLIDING;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        model_reset();
        do_reset("init");

        // Sliding window fill and first averages.
        cycle(0, MODE_SLIDING, 1, 4,  "s030a");
        cycle(0, MODE_SLIDING, 1, 8,  "s030b");
        cycle(0, MODE_SLIDING, 0, 0,  "s030gap");
        cycle(0, MODE_SLIDING, 1, 12, "s030c");
        cycle(0, MODE_SLIDING, 1, 16, "s030d");
        check_val("s030_avg10", {24'd0, out_data}, 32'd10);
        check_val("s030_warm", {31'd0, warm}, 32'd1);
        cycle(0, MODE_SLIDING, 1, 20, "s030e");
        check_val("s030_avg14", {24'd0, out_data}, 32'd14);

        // Block averaging with decimation.
        cycle(0, MODE_BLOCK, 0, 0, "b031sw");
        p0 = pulses;
        for (int i = 1; i <= 8; i++) cycle(0, MODE_BLOCK, 1, i, "b031");
        check_val("b031_avg6", {24'd0, out_data}, 32'd6);
        check_val("b031_pulses", pulses - p0, 32'd2);

        // Full-scale samples must not wrap the sum.
        cycle(0, MODE_SLIDING, 0, 0, "s032sw");
        for (int i = 0; i < 6; i++) cycle(0, MODE_SLIDING, 1, 255, "s032");
        check_val("s032_avg255", {24'd0, out_data}, 32'd255);

        // Clear drops its coincident sample and restarts the window.
        cycle(0, MODE_SLIDING, 1, 50, "s033a");
        cycle(0, MODE_SLIDING, 1, 50, "s033b");
        cycle(1, MODE_SLIDING, 1, 200, "s033clr");
        for (int i = 0; i < 4; i++) cycle(0, MODE_SLIDING, 1, 100, "s033");
        check_val("s033_avg100", {24'd0, out_data}, 32'd100);

        // Reset mid-stream aborts the partial window.
        for (int i = 0; i < 3; i++) cycle(0, MODE_SLIDING, 1, 40, "s034a");
        do_reset("s034");
        p0 = pulses;
        for (int i = 0; i < 4; i++) cycle(0, MODE_SLIDING, 1, 80, "s034b");
        check_val("s034_avg80", {24'd0, out_data}, 32'd80);
        check_val("s034_pulses", pulses - p0, 32'd1);

        // Mode switch while warm flushes and starts a block window.
        check_val("s035_warm_before", {31'd0, warm}, 32'd1);
        cycle(0, MODE_BLOCK, 0, 0, "b035sw");
        p0 = pulses;
        for (int i = 0; i < 4; i++) cycle(0, MODE_BLOCK, 1, 8, "b035");
        check_val("b035_avg8", {24'd0, out_data}, 32'd8);
        check_val("b035_pulses", pulses - p0, 32'd1);

        // Randomized traffic with occasional clear, mode flips and resets.
        begin
            mode_e md;
            md = MODE_BLOCK;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 599) == 0) begin
                    do_reset("rnd");
                    md = MODE_SLIDING;
                end
                if ($urandom_range(0, 79) == 0) md = (md == MODE_SLIDING) ? MODE_BLOCK : MODE_SLIDING;
                cycle(($urandom_range(0, 99) == 0), md, ($urandom_range(0, 9) < 6),
                      int'($urandom_range(0, 255)), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
